ema_filter: RTL and testbench

//  Streaming first-order exponential moving average (EMA) filter for 8-bit samples.

---
 rtl/ema_pkg.sv | 29 ++
 rtl/ema_datapath.sv | 68 ++++++
 rtl/ema_filter.sv | 111 +++++++++++
 tb/tb_ema_filter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ema_pkg.sv
// rtl/ema_pkg.sv - shared widths, FSM states, saturation limits and rounding constant for ema_filter
package ema_pkg;

  localparam int EMA_DATA_W  = 8;
  localparam int EMA_ALPHA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    UPD  = 2'd2
  } ema_state_e;

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int EMA_SAT_MAX = sat_hi(EMA_DATA_W);
  localparam int EMA_SAT_MIN = sat_lo(EMA_DATA_W);

  // Half an output LSB once the product is scaled down by 2^shift.
  function automatic int round_const(input int shift);
    return (shift > 0) ? (1 << (shift - 1)) : 0;
  endfunction

endpackage

// File: rtl/ema_datapath.sv
// rtl/ema_datapath.sv - EMA subtract/multiply (registered product) and scale/saturate
// EMA_ROUND_EN selects round-half-up scaling instead of floor.
module ema_datapath
  import ema_pkg::*;
#(
  parameter int DATA_W  = EMA_DATA_W,
  parameter int ALPHA_W = EMA_ALPHA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mul_en,
  input  logic signed [DATA_W-1:0] x,
  input  logic [ALPHA_W-1:0]       alpha,
  input  logic signed [DATA_W-1:0] y,
  output logic signed [DATA_W-1:0] y_next
);

  localparam int D_W = DATA_W + 1;
  localparam int P_W = DATA_W + ALPHA_W + 1;
  localparam int E_W = P_W + 1;

  localparam logic signed [E_W-1:0] MAX_E = E_W'(sat_hi(DATA_W));
  localparam logic signed [E_W-1:0] MIN_E = E_W'(sat_lo(DATA_W));
`ifdef EMA_ROUND_EN
  localparam logic signed [E_W-1:0] RND_E = E_W'(round_const(ALPHA_W));
`else
  localparam logic signed [E_W-1:0] RND_E = '0;
`endif

  logic signed [D_W-1:0] diff;
  logic signed [P_W-1:0] diff_e;
  logic signed [P_W-1:0] alpha_e;
  logic signed [P_W-1:0] p_d;
  logic signed [P_W-1:0] p_q;
  logic signed [E_W-1:0] p_ext;
  logic signed [E_W-1:0] scaled;
  logic signed [E_W-1:0] sum;

  always_comb begin
    diff    = {x[DATA_W-1], x} - {y[DATA_W-1], y};
    diff_e  = P_W'(diff);
    alpha_e = P_W'({1'b0, alpha});
    p_d     = mul_en ? (diff_e * alpha_e) : p_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  // Clamp is kept even though the convex combination stays in range.
  always_comb begin
    p_ext  = {p_q[P_W-1], p_q};
    scaled = (p_ext + RND_E) >>> ALPHA_W;
    sum    = scaled + {{(E_W - DATA_W){y[DATA_W-1]}}, y};
    if (sum > MAX_E) begin
      y_next = MAX_E[DATA_W-1:0];
    end else if (sum < MIN_E) begin
      y_next = MIN_E[DATA_W-1:0];
    end else begin
      y_next = sum[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ema_filter.sv
// rtl/ema_filter.sv - streaming first-order EMA filter top: FSM, valid_i edge detect, output registers
// Build option EMA_ROUND_EN (see ema_datapath) enables rounded scaling.
module ema_filter
  import ema_pkg::*;
#(
  parameter int DATA_W  = EMA_DATA_W,
  parameter int ALPHA_W = EMA_ALPHA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  x_i,
  input  logic [ALPHA_W-1:0] alpha_i,
  input  logic               valid_i,
  output logic [DATA_W-1:0]  y_o,
  output logic               bussy_o,
  output logic               valid_o
);

  ema_state_e state_q, state_d;

  logic               valid_prev_q, valid_prev_d;
  logic [DATA_W-1:0]  x_q, x_d;
  logic [ALPHA_W-1:0] alpha_q, alpha_d;
  logic [DATA_W-1:0]  y_q, y_d;
  logic [DATA_W-1:0]  y_o_q, y_o_d;
  logic               valid_o_q, valid_o_d;

  logic               accept;
  logic               mul_en;
  logic               upd_en;
  logic [DATA_W-1:0]  y_next;

  // Only a rising valid_i seen while idle starts a sample; nothing is queued.
  assign accept = valid_i && !valid_prev_q && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = MUL;
      MUL:     state_d = UPD;
      UPD:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bussy_o = (state_q == MUL) || (state_q == UPD);
    mul_en  = (state_q == MUL);
    upd_en  = (state_q == UPD);
  end

  always_comb begin
    valid_prev_d = valid_i;
    x_d          = x_q;
    alpha_d      = alpha_q;
    y_d          = y_q;
    y_o_d        = y_o_q;
    valid_o_d    = upd_en;
    if (accept) begin
      x_d     = x_i;
      alpha_d = alpha_i;
    end
    if (upd_en) begin
      y_d   = y_next;
      y_o_d = y_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_prev_q <= 1'b0;
      x_q          <= '0;
      alpha_q      <= '0;
      y_q          <= '0;
      y_o_q        <= '0;
      valid_o_q    <= 1'b0;
    end else begin
      valid_prev_q <= valid_prev_d;
      x_q          <= x_d;
      alpha_q      <= alpha_d;
      y_q          <= y_d;
      y_o_q        <= y_o_d;
      valid_o_q    <= valid_o_d;
    end
  end

  ema_datapath #(
    .DATA_W  (DATA_W),
    .ALPHA_W (ALPHA_W)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .mul_en (mul_en),
    .x      (x_q),
    .alpha  (alpha_q),
    .y      (y_q),
    .y_next (y_next)
  );

  assign y_o     = y_o_q;
  assign valid_o = valid_o_q;

endmodule

// File: tb/tb_ema_filter.sv
// tb/tb_ema_filter.sv - scoreboard bench for ema_filter; honours EMA_ROUND_EN
module tb_ema_filter;

`ifdef EMA_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] x_i = '0;
  logic [7:0] alpha_i = '0;
  logic       valid_i = 1'b0;
  wire  [7:0] y_o;
  wire        bussy_o;
  wire        valid_o;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  int y_model = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  ema_filter dut (
    .clk     (clk),
    .rst     (rst),
    .x_i     (x_i),
    .alpha_i (alpha_i),
    .valid_i (valid_i),
    .y_o     (y_o),
    .bussy_o (bussy_o),
    .valid_o (valid_o)
  );

  function automatic int model(input int y, input int x, input int a);
    int p;
    int s;
    p = (x - y) * a;
    if (ROUND) p = p + 128;
    s = y + (p >>> 8);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  always @(negedge clk) begin : monitor
    int e;
    int got;
    if (rst && valid_o) begin
      pulses++;
      total++;
      got = $signed(y_o);
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse y_o=%0d expected no pulse", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL scoreboard y_o=%0d expected %0d", got, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int a);
    tick();
    x_i = 8'(x);
    alpha_i = 8'(a);
    valid_i = 1'b1;
    y_model = model(y_model, x, a);
    exp_q.push_back(y_model);
  endtask

  task automatic wait_pulse(input string name);
    int start;
    bit seen;
    start = pulses;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (pulses != start) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout pulses=%0d expected >%0d", name, pulses, start);
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b0;
    valid_i = 1'b0;
    exp_q.delete();
    y_model = 0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int p0;
    #1;
    total += 3;
    if (y_o !== 8'd0) begin bad++; $display("FAIL reset_y y_o=%0d expected 0", y_o); end
    if (bussy_o !== 1'b0) begin bad++; $display("FAIL reset_busy bussy_o=%b expected 0", bussy_o); end
    if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid valid_o=%b expected 0", valid_o); end
    tick();
    rst = 1'b1;
    p0 = pulses;
    repeat (5) tick();
    total += 3;
    if (y_o !== 8'd0) begin bad++; $display("FAIL idle_y y_o=%0d expected 0", y_o); end
    if (bussy_o !== 1'b0) begin bad++; $display("FAIL idle_busy bussy_o=%b expected 0", bussy_o); end
    if (pulses !== p0) begin bad++; $display("FAIL idle_pulses got=%0d expected %0d", pulses - p0, 0); end
  endtask

  task automatic test_basic();
    int p0;
    int pulse_at;
    int npulse;
    p0 = pulses;
    pulse_at = 0;
    npulse = 0;
    drive(100, 102);
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n == 1) begin
        total++;
        if (bussy_o !== 1'b1) begin bad++; $display("FAIL basic_busy bussy_o=%b expected 1", bussy_o); end
      end
      if (valid_o) begin
        pulse_at = n;
        npulse++;
      end
      if (n == 5) valid_i = 1'b0;
    end
    total += 4;
    if (npulse !== 1) begin bad++; $display("FAIL basic_pulse_count got=%0d expected 1", npulse); end
    if (pulse_at !== 3) begin bad++; $display("FAIL basic_latency got=%0d expected 3", pulse_at); end
    if (pulses - p0 !== 1) begin bad++; $display("FAIL basic_hold_accepts got=%0d expected 1", pulses - p0); end
    if ($signed(y_o) !== (ROUND ? 40 : 39)) begin
      bad++; $display("FAIL basic_first y_o=%0d expected %0d", $signed(y_o), ROUND ? 40 : 39);
    end
    drive(100, 102);
    tick();
    valid_i = 1'b0;
    wait_pulse("basic_second");
    total++;
    if ($signed(y_o) !== (ROUND ? 64 : 63)) begin
      bad++; $display("FAIL basic_second y_o=%0d expected %0d", $signed(y_o), ROUND ? 64 : 63);
    end
  endtask

  task automatic test_negative();
    do_reset();
    drive(-100, 102);
    tick();
    valid_i = 1'b0;
    wait_pulse("negative");
    total++;
    if ($signed(y_o) !== -40) begin bad++; $display("FAIL negative y_o=%0d expected -40", $signed(y_o)); end
  endtask

  task automatic test_alpha_edges();
    int y_before;
    do_reset();
    drive(100, 102);
    tick();
    valid_i = 1'b0;
    wait_pulse("alpha_setup");
    y_before = $signed(y_o);
    drive(-128, 0);
    tick();
    valid_i = 1'b0;
    wait_pulse("alpha_zero");
    total++;
    if ($signed(y_o) !== y_before) begin
      bad++; $display("FAIL alpha_zero y_o=%0d expected %0d", $signed(y_o), y_before);
    end
    do_reset();
    drive(127, 255);
    tick();
    valid_i = 1'b0;
    wait_pulse("alpha_max");
    total++;
    if ($signed(y_o) !== (ROUND ? 127 : 126)) begin
      bad++; $display("FAIL alpha_max y_o=%0d expected %0d", $signed(y_o), ROUND ? 127 : 126);
    end
  endtask

  task automatic test_busy_ignore();
    int p0;
    do_reset();
    p0 = pulses;
    drive(50, 128);
    tick();
    valid_i = 1'b0;
    tick();
    valid_i = 1'b1;
    repeat (5) tick();
    valid_i = 1'b0;
    repeat (4) tick();
    total += 2;
    if (pulses - p0 !== 1) begin bad++; $display("FAIL busy_ignore pulses=%0d expected 1", pulses - p0); end
    if (exp_q.size() !== 0) begin bad++; $display("FAIL busy_pending got=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int p0;
    do_reset();
    drive(100, 200);
    tick();
    total++;
    if (bussy_o !== 1'b1) begin bad++; $display("FAIL mid_busy_before bussy_o=%b expected 1", bussy_o); end
    rst = 1'b0;
    #1;
    total += 3;
    if (y_o !== 8'd0) begin bad++; $display("FAIL mid_y y_o=%0d expected 0", y_o); end
    if (bussy_o !== 1'b0) begin bad++; $display("FAIL mid_busy bussy_o=%b expected 0", bussy_o); end
    if (valid_o !== 1'b0) begin bad++; $display("FAIL mid_valid valid_o=%b expected 0", valid_o); end
    exp_q.delete();
    y_model = 0;
    valid_i = 1'b0;
    tick();
    rst = 1'b1;
    p0 = pulses;
    repeat (4) tick();
    total++;
    if (pulses !== p0) begin bad++; $display("FAIL mid_no_pulse got=%0d expected 0", pulses - p0); end
    drive(-60, 64);
    tick();
    valid_i = 1'b0;
    wait_pulse("mid_restart");
    total++;
    if ($signed(y_o) !== -15) begin bad++; $display("FAIL mid_restart y_o=%0d expected -15", $signed(y_o)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_alpha_edges();
    test_busy_ignore();
    test_reset_mid();
    repeat (3) tick();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL final_pending got=%0d expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
